// File: rtl/ni_pkg.sv
// Shared definitions for the NI send-side DMA: state encoding, flit bit
// positions and a ceiling log2 helper used for parameter-derived widths.
package ni_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD,
    ST_SND
  } send_state_e;

  // Ceiling log2, never less than 1 so derived widths stay legal.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Flit layout: {header, tail, payload[Dw-1:0]}.
  function automatic int unsigned flit_hdr_bit(input int unsigned dw);
    return dw + 1;
  endfunction

  function automatic int unsigned flit_tail_bit(input int unsigned dw);
    return dw;
  endfunction

endpackage

// File: rtl/ni_credit_counter.sv
// Router-VC credit counter: starts at B, counts down per flit sent and up per
// credit returned, saturating at B. credit_avail_o is high while count > 0.
module ni_credit_counter
  import ni_pkg::*;
#(
  parameter int unsigned B = 4,
  localparam int unsigned CW = log2(B + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic dec_i,
  output logic credit_avail_o
);

  localparam logic [CW-1:0] BMAX = CW'(B);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: simultaneous inc and dec cancel; returns beyond B are dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (dec_i && !inc_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end else if (inc_i && !dec_i) begin
      if (cnt_q < BMAX) cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register, reloaded with the full buffer depth on reset.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= BMAX;
    else       cnt_q <= cnt_d;
  end

  assign credit_avail_o = (cnt_q != '0);

endmodule

// File: rtl/ni_vc_send_dma.sv
// NI send DMA: reads a payload over a Wishbone master port and injects it as
// header/body/tail flits into one router VC under credit flow control.
// Optional Wishbone error handling is enabled by defining NI_SEND_WB_ERR_EN.
module ni_vc_send_dma
  import ni_pkg::*;
#(
  parameter int unsigned MAX_TRANSACTION_WIDTH = 10,
  parameter int unsigned DST_ADR_HDR_WIDTH     = 8,
  parameter int unsigned NX                    = 4,
  parameter int unsigned NY                    = 4,
  parameter int unsigned C                     = 4,
  parameter int unsigned B                     = 4,
  parameter int unsigned Dw                    = 32,
  parameter int unsigned M_Aw                  = 32,
  localparam int unsigned Xw = log2(NX),
  localparam int unsigned Yw = log2(NY),
  localparam int unsigned Cw = (C > 1) ? log2(C) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             send_start,
  input  logic [Dw-1:0]                    send_start_addr,
  input  logic [MAX_TRANSACTION_WIDTH-1:0] send_data_size,
  input  logic [Xw-1:0]                    dest_x,
  input  logic [Yw-1:0]                    dest_y,
  input  logic [Cw-1:0]                    pck_class,
  output logic                             send_fsm_is_ideal,
  output logic [M_Aw-1:0]                  m_adr_o,
  output logic                             m_cyc_o,
  output logic                             m_stb_o,
  output logic                             m_we_o,
  input  logic [Dw-1:0]                    m_dat_i,
  input  logic                             m_ack_i,
`ifdef NI_SEND_WB_ERR_EN
  input  logic                             m_err_i,
  output logic                             send_err,
`endif
  output logic [Dw+1:0]                    flit_out,
  output logic                             flit_out_wr,
  input  logic                             credit_in
);

  localparam int unsigned FLIT_HDR  = flit_hdr_bit(Dw);
  localparam int unsigned FLIT_TAIL = flit_tail_bit(Dw);
  localparam int unsigned MTW       = MAX_TRANSACTION_WIDTH;

  send_state_e          state_q, state_d;
  logic [M_Aw-1:0]      addr_q, addr_d;
  logic [MTW-1:0]       remain_q, remain_d;
  logic [Dw-1:0]        hdr_q, hdr_d;
  logic [Dw-1:0]        data_q, data_d;
  logic [Dw+1:0]        flit_q, flit_d;
  logic                 flit_wr_q, flit_wr_d;
  logic                 credit_avail;
  logic                 last_word;
`ifdef NI_SEND_WB_ERR_EN
  logic                 trunc_q, trunc_d;
  logic                 err_q, err_d;
`endif

  ni_credit_counter #(
    .B (B)
  ) u_credit (
    .clk            (clk),
    .reset          (reset),
    .inc_i          (credit_in),
    .dec_i          (flit_wr_q),
    .credit_avail_o (credit_avail)
  );

`ifdef NI_SEND_WB_ERR_EN
  // A bus error turns the pending word into the (zero) tail flit.
  assign last_word = (remain_q == MTW'(1)) || trunc_q;
`else
  assign last_word = (remain_q == MTW'(1));
`endif

  // Next-state, datapath and flit generation for the send FSM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    hdr_d     = hdr_q;
    data_d    = data_q;
    flit_d    = flit_q;
    flit_wr_d = 1'b0;
`ifdef NI_SEND_WB_ERR_EN
    trunc_d   = trunc_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (send_start) begin
          addr_d   = M_Aw'(send_start_addr);
          remain_d = send_data_size;
          hdr_d    = '0;
          hdr_d[Xw-1:0]                       = dest_x;
          hdr_d[DST_ADR_HDR_WIDTH/2 +: Yw]    = dest_y;
          hdr_d[DST_ADR_HDR_WIDTH +: Cw]      = pck_class;
`ifdef NI_SEND_WB_ERR_EN
          trunc_d  = 1'b0;
          err_d    = 1'b0;
`endif
          state_d  = ST_HDR;
        end
      end
      ST_HDR: begin
        if (credit_avail) begin
          flit_wr_d           = 1'b1;
          flit_d              = '0;
          flit_d[FLIT_HDR]    = 1'b1;
          flit_d[FLIT_TAIL]   = (remain_q == '0);
          flit_d[Dw-1:0]      = hdr_q;
          state_d             = (remain_q == '0) ? ST_IDLE : ST_RD;
        end
      end
      ST_RD: begin
        if (m_ack_i) begin
          data_d  = m_dat_i;
          state_d = ST_SND;
        end
`ifdef NI_SEND_WB_ERR_EN
        else if (m_err_i) begin
          data_d  = '0;
          trunc_d = 1'b1;
          err_d   = 1'b1;
          state_d = ST_SND;
        end
`endif
      end
      ST_SND: begin
        if (credit_avail) begin
          flit_wr_d         = 1'b1;
          flit_d            = '0;
          flit_d[FLIT_TAIL] = last_word;
          flit_d[Dw-1:0]    = data_q;
          if (last_word) begin
`ifdef NI_SEND_WB_ERR_EN
            trunc_d = 1'b0;
`endif
            state_d = ST_IDLE;
          end else begin
            remain_d = remain_q - MTW'(1);
            addr_d   = addr_q + M_Aw'(1);
            state_d  = ST_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any packet in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      hdr_q     <= '0;
      data_q    <= '0;
      flit_q    <= '0;
      flit_wr_q <= 1'b0;
`ifdef NI_SEND_WB_ERR_EN
      trunc_q   <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      hdr_q     <= hdr_d;
      data_q    <= data_d;
      flit_q    <= flit_d;
      flit_wr_q <= flit_wr_d;
`ifdef NI_SEND_WB_ERR_EN
      trunc_q   <= trunc_d;
      err_q     <= err_d;
`endif
    end
  end

  assign send_fsm_is_ideal = (state_q == ST_IDLE);
  assign m_cyc_o           = (state_q == ST_RD);
  assign m_stb_o           = (state_q == ST_RD);
  assign m_we_o            = 1'b0;
  assign m_adr_o           = addr_q;
  assign flit_out          = flit_q;
  assign flit_out_wr       = flit_wr_q;
`ifdef NI_SEND_WB_ERR_EN
  assign send_err          = err_q;
`endif

endmodule

// File: tb/tb_ni_vc_send_dma.sv
// Self-checking bench for ni_vc_send_dma (default parameters).
// Table-driven packets plus hand-written credit-stall and mid-packet reset
// sequences; the error-port sequence is built only with NI_SEND_WB_ERR_EN.
`timescale 1ns/1ps
module tb_ni_vc_send_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        send_start = 1'b0;
  logic [31:0] send_start_addr = '0;
  logic [9:0]  send_data_size = '0;
  logic [1:0]  dest_x = '0, dest_y = '0, pck_class = '0;
  logic        send_fsm_is_ideal;
  logic [31:0] m_adr_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [31:0] m_dat_i = '0;
  logic        m_ack_i = 1'b0;
  logic        m_err_i = 1'b0;
  logic        send_err;
  logic [33:0] flit_out;
  logic        flit_out_wr;
  logic        credit_in = 1'b0;

  ni_vc_send_dma dut (
    .clk               (clk),
    .reset             (reset),
    .send_start        (send_start),
    .send_start_addr   (send_start_addr),
    .send_data_size    (send_data_size),
    .dest_x            (dest_x),
    .dest_y            (dest_y),
    .pck_class         (pck_class),
    .send_fsm_is_ideal (send_fsm_is_ideal),
    .m_adr_o           (m_adr_o),
    .m_cyc_o           (m_cyc_o),
    .m_stb_o           (m_stb_o),
    .m_we_o            (m_we_o),
    .m_dat_i           (m_dat_i),
    .m_ack_i           (m_ack_i),
`ifdef NI_SEND_WB_ERR_EN
    .m_err_i           (m_err_i),
    .send_err          (send_err),
`endif
    .flit_out          (flit_out),
    .flit_out_wr       (flit_out_wr),
    .credit_in         (credit_in)
  );

`ifndef NI_SEND_WB_ERR_EN
  assign send_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  logic [31:0] mem [0:1023];
  logic [33:0] flits[$];
  logic [31:0] adrs[$];
  int unsigned bus_cnt = 0;
  int unsigned wcnt = 0;
  int unsigned ack_dly = 1;
  int          err_word = -1;
  bit          auto_credit = 1'b1;
  logic [2:0]  dut_cnt;
  logic [2:0]  max_cnt = '0;

  assign dut_cnt = dut.u_credit.cnt_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Router sink and Wishbone memory slave, both sampled on the falling edge.
  always @(negedge clk) begin
    if (auto_credit) credit_in = flit_out_wr;
    if (flit_out_wr) flits.push_back(flit_out);
    if (dut_cnt > max_cnt) max_cnt = dut_cnt;
    if (m_cyc_o && m_stb_o) bus_cnt++;
    if (m_cyc_o && m_stb_o && !m_ack_i && !m_err_i) begin
      if (wcnt == ack_dly) begin
        if (err_word >= 0 && adrs.size() == err_word) begin
          m_err_i = 1'b1;
        end else begin
          m_ack_i = 1'b1;
          m_dat_i = mem[m_adr_o[9:0]];
        end
        adrs.push_back(m_adr_o);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      m_ack_i = 1'b0;
      m_err_i = 1'b0;
      wcnt    = 0;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [9:0]  size;
    logic [1:0]  dx, dy, cls;
    int unsigned dly;
    logic [31:0] hdr;     // expected header payload
    int unsigned cycles;  // start cycle to idle: 2 + N*(dly+2)
    int unsigned bus;     // cycles with cyc/stb high: N*(dly+1)
  } vec_t;

  vec_t vecs[5];

  task automatic start_pkt(input logic [31:0] a, input logic [9:0] n,
                           input logic [1:0] x, input logic [1:0] y, input logic [1:0] c);
    flits.delete();
    adrs.delete();
    bus_cnt         = 0;
    send_start_addr = a;
    send_data_size  = n;
    dest_x          = x;
    dest_y          = y;
    pck_class       = c;
    send_start      = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int unsigned bound, output int unsigned cyc);
    cyc = 0;
    do begin
      tick();
      send_start = 1'b0;
      cyc++;
    end while (!send_fsm_is_ideal && cyc < bound);
    if (!send_fsm_is_ideal) chk({name, "_timeout"}, 64'(cyc), 64'(bound + 1));
  endtask

  initial begin
    int unsigned cyc;
    int unsigned tails;
    logic [31:0] a;

    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);

    vecs[0] = '{32'h0000_0100, 10'd3, 2'd2, 2'd1, 2'd1, 1, 32'h112, 11, 6};
    vecs[1] = '{32'h0000_0200, 10'd0, 2'd3, 2'd3, 2'd3, 1, 32'h333,  2, 0};
    vecs[2] = '{32'h0000_03FE, 10'd2, 2'd0, 2'd2, 2'd2, 5, 32'h220, 16, 12};
    vecs[3] = '{32'h0000_0050, 10'd1, 2'd1, 2'd0, 2'd0, 1, 32'h001,  5, 2};
    vecs[4] = '{32'hFFFF_FFFF, 10'd2, 2'd1, 2'd1, 2'd0, 1, 32'h011,  8, 4};

    // Reset state.
    tick(); tick(); tick();
    chk("rst_ideal",   64'(send_fsm_is_ideal), 64'd1);
    chk("rst_cyc",     64'(m_cyc_o),           64'd0);
    chk("rst_stb",     64'(m_stb_o),           64'd0);
    chk("rst_we",      64'(m_we_o),            64'd0);
    chk("rst_adr",     64'(m_adr_o),           64'd0);
    chk("rst_flit",    64'(flit_out),          64'd0);
    chk("rst_flit_wr", 64'(flit_out_wr),       64'd0);
    chk("rst_credit",  64'(dut_cnt),           64'd4);
    reset = 1'b0;
    tick();

    // Table-driven packets with a credit returned in the same cycle as each flit.
    foreach (vecs[v]) begin
      ack_dly = vecs[v].dly;
      chk($sformatf("v%0d_ideal_before", v), 64'(send_fsm_is_ideal), 64'd1);
      start_pkt(vecs[v].addr, vecs[v].size, vecs[v].dx, vecs[v].dy, vecs[v].cls);
      wait_idle($sformatf("v%0d", v), 200, cyc);
      tick();
      chk($sformatf("v%0d_cycles", v),  64'(cyc),          64'(vecs[v].cycles));
      chk($sformatf("v%0d_bus", v),     64'(bus_cnt),      64'(vecs[v].bus));
      chk($sformatf("v%0d_nflits", v),  64'(flits.size()), 64'(vecs[v].size) + 64'd1);
      chk($sformatf("v%0d_credit", v),  64'(dut_cnt),      64'd4);
      if (flits.size() == int'(vecs[v].size) + 1) begin
        chk($sformatf("v%0d_hdr", v), 64'(flits[0]),
            64'({1'b1, (vecs[v].size == 10'd0), vecs[v].hdr}));
        for (int k = 0; k < int'(vecs[v].size); k++) begin
          a = vecs[v].addr + 32'(k);
          chk($sformatf("v%0d_flit%0d", v, k), 64'(flits[k+1]),
              64'({1'b0, (k == int'(vecs[v].size) - 1), 32'hC0DE_0000 | {22'd0, a[9:0]}}));
          if (k < adrs.size()) chk($sformatf("v%0d_adr%0d", v, k), 64'(adrs[k]), 64'(a));
        end
      end
    end
    ack_dly = 1;

    // Credit stall: no credits returned, so only B = 4 flits may leave.
    auto_credit = 1'b0;
    credit_in   = 1'b0;
    start_pkt(32'h0000_0010, 10'd8, 2'd1, 2'd2, 2'd0);
    tick();
    send_start = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("stall_nflits", 64'(flits.size()),       64'd4);
    chk("stall_credit", 64'(dut_cnt),            64'd0);
    chk("stall_cyc",    64'(m_cyc_o),            64'd0);
    chk("stall_ideal",  64'(send_fsm_is_ideal),  64'd0);
    credit_in = 1'b1;
    wait_idle("stall_resume", 200, cyc);
    tick(); tick(); tick();
    credit_in = 1'b0;
    tails = 0;
    foreach (flits[k]) if (flits[k][32]) tails++;
    chk("stall_total",    64'(flits.size()), 64'd9);
    chk("stall_tails",    64'(tails),        64'd1);
    if (flits.size() == 9) begin
      chk("stall_last_tail", 64'(flits[8][32]),   64'd1);
      chk("stall_last_data", 64'(flits[8][31:0]), 64'h0000_0000_C0DE_0017);
    end
    chk("stall_credit_end", 64'(dut_cnt), 64'd4);
    chk("credit_max",       64'(max_cnt), 64'd4);
    auto_credit = 1'b1;
    tick();

    // Reset after two data flits, while the third word is being read.
    start_pkt(32'h0000_0300, 10'd4, 2'd2, 2'd2, 2'd1);
    cyc = 0;
    do begin
      tick();
      send_start = 1'b0;
      cyc++;
    end while (!(flits.size() == 3 && m_cyc_o) && cyc < 100);
    chk("mid_reached", 64'(flits.size() == 3 && m_cyc_o), 64'd1);
    reset = 1'b1;
    tick();
    chk("mid_cyc",     64'(m_cyc_o),           64'd0);
    chk("mid_stb",     64'(m_stb_o),           64'd0);
    chk("mid_ideal",   64'(send_fsm_is_ideal), 64'd1);
    chk("mid_credit",  64'(dut_cnt),           64'd4);
    chk("mid_flit_wr", 64'(flit_out_wr),       64'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    tails = 0;
    foreach (flits[k]) if (flits[k][32]) tails++;
    chk("mid_nflits", 64'(flits.size()), 64'd3);
    chk("mid_no_tail", 64'(tails),       64'd0);

`ifdef NI_SEND_WB_ERR_EN
    // Bus error on the second of four words truncates the packet.
    err_word = 1;
    start_pkt(32'h0000_0080, 10'd4, 2'd1, 2'd1, 2'd1);
    wait_idle("err", 200, cyc);
    tick();
    err_word = -1;
    chk("err_nflits", 64'(flits.size()), 64'd3);
    if (flits.size() == 3) chk("err_tail_flit", 64'(flits[2]), 64'h1_0000_0000);
    chk("err_flag", 64'(send_err), 64'd1);
    start_pkt(32'h0000_0090, 10'd0, 2'd0, 2'd0, 2'd0);
    tick();
    send_start = 1'b0;
    chk("err_clear", 64'(send_err), 64'd0);
    wait_idle("err_next", 50, cyc);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
